spi_master_ctrl: RTL and testbench
==================================

# spi_master_ctrl

SPI initiator for the SPI slave/RAM subsystem. Accepts parallel RAM commands on a valid/ready request port and serializes each into one 11-bit SPI frame on `ss_n`/`mosi`. For read-data commands it also captures the 8-bit reply on `miso` and returns it on a response port. It sits between on-chip control logic and the `slave_ram_top_module` SPI pins.

## Interface
- `TURN_CYCLES`, default 2: `ss_n`-low cycles between the last frame bit and the first `miso` sample, read-data only; legal range 0–7.
- `GAP_CYCLES`, default 1: forced `ss_n`-high cycles after every frame; legal range 1–7.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: command request.
- `req_ready` out 1: block can accept a command; high only in IDLE.
- `req_op` in 2: 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
- `req_data` in 8: address or write data; ignored for RD_DATA.
- `rsp_valid` out 1: one-cycle pulse, RD_DATA reply is valid.
- `rsp_data` out 8: captured read byte; holds until the next RD_DATA completes.
- `ss_n` out 1: slave select, active low, registered.
- `mosi` out 1: serial data to slave, registered.
- `miso` in 1: serial data from slave.

## Operation
- **Frame:** 11 bits, MSB first.
  - Frame = {`req_op[1]`, `req_op`, payload}. Bit 10 is the command bit: 0 for writes, 1 for reads.
  - Payload = `req_data`. For RD_DATA, payload = 8'hFF (dummy byte).
- **States:** IDLE, SHIFT, TURN, CAPTURE, GAP.
- **IDLE:**
  - `ss_n`=1, `mosi`=0, `req_ready`=1.
  - A handshake (`req_valid`&&`req_ready` at a rising edge) latches the frame and the op, clears the bit counter, and goes to SHIFT.
- **SHIFT:**
  - `ss_n`=0. On counter value k (0..10), `mosi`=frame[10-k].
  - After k=10: RD_DATA goes to TURN, or directly to CAPTURE if `TURN_CYCLES`=0. All other ops go to GAP.
- **TURN:** `ss_n`=0, `mosi`=0, lasts `TURN_CYCLES` cycles.
- **CAPTURE:**
  - `ss_n`=0, `mosi`=0, lasts 8 cycles.
  - `miso` is sampled at the rising edge that ends each cycle and shifted in MSB first.
  - After the 8th sample, go to GAP.
- **GAP:**
  - `ss_n`=1, `mosi`=0, lasts `GAP_CYCLES` cycles, then IDLE.
  - `rsp_valid`=1 in the first GAP cycle after CAPTURE only.
- **Reset:** asynchronous. Assertion at any point, including mid-frame, immediately forces:
  - `ss_n`=1, `mosi`=0, `rsp_valid`=0, `rsp_data`=0.
  - State IDLE; counters 0; any partial frame discarded.
  - `req_ready` is 1 during and after reset.
- **No command checking:**
  - RD_DATA without a prior RD_ADDR is still issued as-is.
  - `req_valid` while not ready is ignored; requests are not queued.

## Timing
- Handshake at edge E0 → first frame bit on `mosi` with `ss_n`=0 in cycle E0+1.
- Write, WR_ADDR, RD_ADDR frames:
  - `ss_n` low for exactly 11 cycles, then high for `GAP_CYCLES`.
  - `req_ready` returns 11+`GAP_CYCLES`+1 cycles after the handshake.
- RD_DATA frames:
  - `ss_n` low for 11+`TURN_CYCLES`+8 cycles (21 at defaults).
  - `rsp_valid` pulses in the cycle after the 8th capture edge.
  - Handshake-to-`rsp_valid` = 11+`TURN_CYCLES`+8+1 cycles (22 at defaults).
- Minimum `ss_n`-high time between back-to-back frames = `GAP_CYCLES`+1 cycles.
- `rsp_data` updates in the same cycle `rsp_valid` rises.

## Structure
- **Package `spi_pkg`:**
  - Op enum (WR_ADDR, WR_DATA, RD_ADDR, RD_DATA).
  - `FRAME_W`=11, `DATA_W`=8, `RD_DUMMY`=8'hFF.
  - FSM state typedef.
- **Sub-module `spi_frame_shifter`:**
  - 11-bit parallel-load, MSB-out shift register.
  - 8-bit serial-in capture register with a 4-bit bit counter.
- The top module holds the FSM, the TURN/GAP counters and the response logic.

## Test plan
- Reset mid-SHIFT (assert `rst_n`=0 at bit 5) → `ss_n`=1, `mosi`=0 with no clock edge. After release, `req_ready`=1 and the next request produces a clean full frame.
- WR_ADDR 8'h3C → `mosi` sequence 0,0,0,0,0,1,1,1,1,0,0 over 11 `ss_n`-low cycles, then `ss_n` high for 1 cycle, then `req_ready`=1.
- RD_DATA with a bench slave model driving 8'hA5 on `miso` starting at low-cycle 14 → `mosi`=1,1,1,1,1,1,1,1,1,1,1; `ss_n` low for 21 cycles; `rsp_valid` pulses at handshake+22; `rsp_data`=8'hA5.
- Full loop against `slave_ram_top_module`: 7 random addresses, each WR_ADDR a, WR_DATA 8'hAA, RD_ADDR a, RD_DATA → every `rsp_data`=8'hAA.
- Back-to-back requests with `req_valid` held high → exactly `GAP_CYCLES`+1 `ss_n`-high cycles between frames; requests presented while not ready are not accepted.
- `TURN_CYCLES`=0 → capture starts the cycle after bit 10; `rsp_valid` at handshake+20.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI initiator: op encoding, FSM states,
// request payload and the frame builder.
package spi_pkg;

    localparam int unsigned FRAME_W = 11;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned TMR_W   = 3;

    localparam logic [DATA_W-1:0] RD_DUMMY = 8'hFF;

    typedef enum logic [OP_W-1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } spi_op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_TURN    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_GAP     = 3'd4
    } spi_state_e;

    typedef struct packed {
        spi_op_e             op;
        logic [DATA_W-1:0]   data;
    } spi_req_t;

    // Frame = {command bit, op, payload}; RD_DATA sends a dummy payload.
    function automatic logic [FRAME_W-1:0] build_frame(input spi_req_t req);
        logic [OP_W-1:0]   op_bits;
        logic [DATA_W-1:0] payload;
        op_bits = req.op;
        payload = (req.op == OP_RD_DATA) ? RD_DUMMY : req.data;
        return {op_bits[OP_W-1], op_bits, payload};
    endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// Frame datapath: 11-bit parallel-load MSB-first shifter, 8-bit serial capture
// register and the shared bit counter used by both phases.
module spi_frame_shifter
    import spi_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [FRAME_W-1:0] frame_i,
    input  logic               shift_i,
    input  logic               capture_i,
    input  logic               miso_i,
    output logic               next_bit_c_o,
    output logic               shift_last_c_o,
    output logic               cap_last_c_o,
    output logic [DATA_W-1:0]  cap_next_c_o
);

    logic [FRAME_W-1:0] sr_q;
    logic [DATA_W-1:0]  cap_q;
    logic [CNT_W-1:0]   cnt_q;

    assign shift_last_c_o = (cnt_q == CNT_W'(FRAME_W - 1));
    assign cap_last_c_o   = (cnt_q == CNT_W'(DATA_W - 1));
    assign cap_next_c_o   = DATA_W'({cap_q, miso_i});

    // Bit driven in the following cycle: frame MSB on load, else the bit behind the current one.
    assign next_bit_c_o = load_i ? frame_i[FRAME_W-1] : sr_q[FRAME_W-2];

    // Counter wraps to zero at the end of each phase so the next phase starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cap_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            sr_q  <= frame_i;
            cnt_q <= '0;
        end else if (shift_i) begin
            sr_q  <= sr_q << 1;
            cnt_q <= shift_last_c_o ? '0 : cnt_q + CNT_W'(1);
        end else if (capture_i) begin
            cap_q <= cap_next_c_o;
            cnt_q <= cap_last_c_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI initiator: accepts RAM commands, serializes each into an 11-bit frame and
// returns the captured byte for RD_DATA. All pin-facing outputs are registered.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              ss_n,
    output logic              mosi,
    input  logic              miso
);

    spi_state_e        state_q, state_d;
    spi_op_e           op_q, op_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              ss_n_q, ss_n_d;
    logic              mosi_q, mosi_d;
    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    spi_req_t           req_c;
    logic [FRAME_W-1:0] frame_c;
    logic               load_c;
    logic               shift_c;
    logic               capture_c;
    logic               next_bit_c;
    logic               shift_last_c;
    logic               cap_last_c;
    logic [DATA_W-1:0]  cap_next_c;

    assign req_c   = '{op: spi_op_e'(req_op), data: req_data};
    assign frame_c = build_frame(req_c);

    spi_frame_shifter u_shifter (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_i         (load_c),
        .frame_i        (frame_c),
        .shift_i        (shift_c),
        .capture_i      (capture_c),
        .miso_i         (miso),
        .next_bit_c_o   (next_bit_c),
        .shift_last_c_o (shift_last_c),
        .cap_last_c_o   (cap_last_c),
        .cap_next_c_o   (cap_next_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_WR_ADDR;
            tmr_q       <= '0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            tmr_q       <= tmr_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Next state, datapath strobes, and pin values for the coming cycle.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        tmr_d       = tmr_q;
        load_c      = 1'b0;
        shift_c     = 1'b0;
        capture_c   = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    load_c  = 1'b1;
                    op_d    = req_c.op;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_c = 1'b1;
                if (shift_last_c) begin
                    tmr_d = '0;
                    if (op_q != OP_RD_DATA) begin
                        state_d = ST_GAP;
                    end else if (TURN_CYCLES == 0) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        state_d = ST_TURN;
                    end
                end
            end
            ST_TURN: begin
                if (tmr_q == TMR_W'(TURN_CYCLES - 1)) begin
                    tmr_d   = '0;
                    state_d = ST_CAPTURE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_CAPTURE: begin
                capture_c = 1'b1;
                if (cap_last_c) begin
                    state_d     = ST_GAP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = cap_next_c;
                end
            end
            ST_GAP: begin
                if (tmr_q == TMR_W'(GAP_CYCLES - 1)) begin
                    tmr_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ss_n_d  = !((state_d == ST_SHIFT) || (state_d == ST_TURN) || (state_d == ST_CAPTURE));
        mosi_d  = (state_d == ST_SHIFT) ? next_bit_c : 1'b0;
        ready_d = (state_d == ST_IDLE);
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign ss_n      = ss_n_q;
    assign mosi      = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural SPI RAM slave model;
// a second instance covers the zero-turnaround configuration.
module tb_spi_master_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req_valid, req_ready, rsp_valid, ss_n, mosi, miso;
    logic [1:0] req_op;
    logic [7:0] req_data, rsp_data;

    logic       req_valid0, req_ready0, rsp_valid0, ss_n0, mosi0, miso0;
    logic [1:0] req_op0;
    logic [7:0] req_data0, rsp_data0;

    int checks   = 0;
    int failures = 0;

    spi_master_ctrl #(.TURN_CYCLES(2), .GAP_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_data(req_data), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .ss_n(ss_n), .mosi(mosi), .miso(miso)
    );

    spi_master_ctrl #(.TURN_CYCLES(0), .GAP_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_op(req_op0), .req_data(req_data0), .rsp_valid(rsp_valid0),
        .rsp_data(rsp_data0), .ss_n(ss_n0), .mosi(mosi0), .miso(miso0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave RAM model: WR_ADDR sets write pointer, WR_DATA stores, RD_ADDR sets
    // read pointer, RD_DATA replies from low-cycle 14 (TURN_CYCLES=2).
    logic [10:0] s_frame;
    int          s_lc;
    logic [7:0]  s_waddr, s_raddr, s_rbyte;
    logic [7:0]  s_mem [256];

    always @(posedge clk) begin
        if (!rst_n) begin
            s_lc    <= 0;
            s_frame <= '0;
            s_waddr <= '0;
            s_raddr <= '0;
            for (int i = 0; i < 256; i++) s_mem[i] <= 8'h00;
        end else if (!ss_n) begin
            s_lc <= s_lc + 1;
            if (s_lc < 11) s_frame <= {s_frame[9:0], mosi};
        end else if (s_lc > 0) begin
            s_lc <= 0;
            if (s_lc >= 11) begin
                case (s_frame[9:8])
                    2'b00:   s_waddr <= s_frame[7:0];
                    2'b01:   s_mem[s_waddr] <= s_frame[7:0];
                    2'b10:   s_raddr <= s_frame[7:0];
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        s_rbyte = s_mem[s_raddr];
        if (s_lc >= 13 && s_lc < 21) miso <= s_rbyte[3'(20 - s_lc)];
        else                         miso <= 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first cycle after the handshake.
    task automatic do_hs(input logic [1:0] op, input logic [7:0] data);
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hs_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Observe cycles 1.. after handshake until req_ready returns.
    task automatic watch(output logic [20:0] bits, output int nlow, output int t_ready,
                         output int t_rsp, output int n_rsp);
        bits = '0; nlow = 0; t_ready = 0; t_rsp = 0; n_rsp = 0;
        for (int c = 1; c <= 60; c++) begin
            if (!ss_n) begin
                if (nlow < 21) bits = {bits[19:0], mosi};
                nlow++;
            end
            if (rsp_valid) begin
                n_rsp++;
                if (t_rsp == 0) t_rsp = c;
            end
            if (req_ready) begin
                t_ready = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic xfer(input logic [1:0] op, input logic [7:0] data, output logic [20:0] bits,
                        output int nlow, output int t_ready, output int t_rsp, output int n_rsp);
        do_hs(op, data);
        watch(bits, nlow, t_ready, t_rsp, n_rsp);
    endtask

    logic [20:0] bits;
    int          nlow, t_ready, t_rsp, n_rsp;
    logic [7:0]  addr;
    logic [7:0]  pat;
    int          hi_run, nfall, nrdy, idx;
    logic        prev_ss;

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_op = '0; req_data = '0;
        req_valid0 = 1'b0; req_op0 = '0; req_data0 = '0; miso0 = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_ready",     32'(req_ready), 32'd1);
        check("rst_ss_n",      32'(ss_n),      32'd1);
        check("rst_mosi",      32'(mosi),      32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(rsp_data),  32'd0);
        check("rst_ready0",    32'(req_ready0), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // WR_ADDR 3C: frame 0_00_00111100
        xfer(2'b00, 8'h3C, bits, nlow, t_ready, t_rsp, n_rsp);
        check("wra_bits",  32'(bits[10:0]), 32'h03C);
        check("wra_nlow",  32'(nlow),       32'd11);
        check("wra_ready", 32'(t_ready),    32'd13);
        check("wra_rsp",   32'(n_rsp),      32'd0);

        // WR_DATA A5: frame 0_01_10100101
        xfer(2'b01, 8'hA5, bits, nlow, t_ready, t_rsp, n_rsp);
        check("wrd_bits",  32'(bits[10:0]), 32'h1A5);
        check("wrd_nlow",  32'(nlow),       32'd11);

        // RD_ADDR 3C: frame 1_10_00111100
        xfer(2'b10, 8'h3C, bits, nlow, t_ready, t_rsp, n_rsp);
        check("rda_bits",  32'(bits[10:0]), 32'h63C);

        // RD_DATA: all-ones frame, then 10 low cycles with mosi=0
        xfer(2'b11, 8'h00, bits, nlow, t_ready, t_rsp, n_rsp);
        check("rdd_bits",     32'(bits),     32'h1FFC00);
        check("rdd_nlow",     32'(nlow),     32'd21);
        check("rdd_t_rsp",    32'(t_rsp),    32'd22);
        check("rdd_n_rsp",    32'(n_rsp),    32'd1);
        check("rdd_ready",    32'(t_ready),  32'd23);
        check("rdd_rsp_data", 32'(rsp_data), 32'hA5);

        // Reset asserted between clock edges while bit 5 (a 1) of WR_DATA FF is on mosi
        do_hs(2'b01, 8'hFF);
        repeat (5) @(negedge clk);
        check("mid_mosi_pre", 32'(mosi), 32'd1);
        check("mid_ss_n_pre", 32'(ss_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_ss_n",      32'(ss_n),      32'd1);
        check("mid_mosi",      32'(mosi),      32'd0);
        check("mid_ready",     32'(req_ready), 32'd1);
        check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rsp_data",  32'(rsp_data),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);
        xfer(2'b00, 8'h3C, bits, nlow, t_ready, t_rsp, n_rsp);
        check("post_rst_bits",  32'(bits[10:0]), 32'h03C);
        check("post_rst_nlow",  32'(nlow),       32'd11);
        check("post_rst_ready2", 32'(t_ready),   32'd13);

        // Write/read loop through the slave model
        for (int i = 0; i < 7; i++) begin
            addr = 8'($urandom_range(0, 255));
            xfer(2'b00, addr,  bits, nlow, t_ready, t_rsp, n_rsp);
            xfer(2'b01, 8'hAA, bits, nlow, t_ready, t_rsp, n_rsp);
            xfer(2'b10, addr,  bits, nlow, t_ready, t_rsp, n_rsp);
            xfer(2'b11, 8'h00, bits, nlow, t_ready, t_rsp, n_rsp);
            check($sformatf("loop%0d_rsp_data", i), 32'(rsp_data), 32'hAA);
            check($sformatf("loop%0d_t_rsp", i),    32'(t_rsp),    32'd22);
        end

        // Back-to-back with req_valid held high: frames at cycles 1, 14, 27
        req_valid = 1'b1; req_op = 2'b01; req_data = 8'h55;
        hi_run = 0; nfall = 0; nrdy = 0; prev_ss = 1'b1;
        for (int i = 0; i < 39; i++) begin
            if (req_ready) nrdy++;
            if (!ss_n && prev_ss) begin
                nfall++;
                if (nfall > 1) check($sformatf("b2b_gap%0d", nfall), 32'(hi_run), 32'd2);
                hi_run = 0;
            end
            if (ss_n) hi_run++;
            prev_ss = ss_n;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b_frames", 32'(nfall), 32'd3);
        check("b2b_ready",  32'(nrdy),  32'd3);

        // TURN_CYCLES=0 instance: capture cycles 12..19, reply 8'h3A
        pat = 8'h3A;
        repeat (3) @(negedge clk);
        req_valid0 = 1'b1; req_op0 = 2'b11; req_data0 = 8'h00;
        @(posedge clk);
        @(negedge clk);
        req_valid0 = 1'b0;
        nlow = 0; t_rsp = 0;
        for (int c = 1; c <= 25; c++) begin
            if (!ss_n0) nlow++;
            if (rsp_valid0 && t_rsp == 0) t_rsp = c;
            if (c >= 12 && c <= 19) begin
                idx = 19 - c;
                miso0 = pat[idx[2:0]];
            end else begin
                miso0 = 1'b0;
            end
            @(negedge clk);
        end
        check("t0_nlow",     32'(nlow),      32'd19);
        check("t0_t_rsp",    32'(t_rsp),     32'd20);
        check("t0_rsp_data", 32'(rsp_data0), 32'h3A);
        check("t0_ready",    32'(req_ready0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
